// File: rtl/dsp_pkg.sv
// Shared types and limits for the DSP48A1 pipeline control logic.
package dsp_pkg;

  typedef enum logic [1:0] {
    DSP_CTRL_INIT,
    DSP_CTRL_RUN,
    DSP_CTRL_FLUSH
  } dsp_ctrl_state_t;

  localparam int DSP_MAX_STAGES = 4;
  localparam int DSP_OCC_W      = 3;

endpackage

// File: rtl/dsp_pipe_ctrl.sv
// Elastic pipeline sequencer for the DSP48A1 slice: per-stage clock enables
// and synchronous clears, per-stage valid tracking with bubble collapse,
// valid/ready handshakes at both ends and a level-sensitive flush.
module dsp_pipe_ctrl
  import dsp_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [STAGES-1:0]    ce,
  output logic [STAGES-1:0]    clr,
  output logic [DSP_OCC_W-1:0] occupancy,
  output logic                 busy
);

  localparam int L = STAGES - 1;

  if (STAGES < 1 || STAGES > DSP_MAX_STAGES) begin : g_bad_stages
    $error("dsp_pipe_ctrl: STAGES must be in 1..%0d", DSP_MAX_STAGES);
  end

  dsp_ctrl_state_t        state_q;
  logic [STAGES-1:0]      v_q, v_d;
  logic [DSP_OCC_W-1:0]   occ_q, occ_d;
  logic [STAGES-1:0]      move;
  logic [STAGES-1:0]      load;
  logic                   in_ready_run;
  logic                   clear_mode;

  // Clearing covers INIT and every cycle flush is high, so a flush wins over
  // any same-cycle handshake and clr tracks the flush level exactly.
  assign clear_mode = (state_q == DSP_CTRL_INIT) | flush;

  // Drain condition ripples from the output end toward the input end.
  assign move[L] = v_q[L] & out_ready;
  for (genvar i = 0; i < L; i++) begin : g_move
    assign move[i] = v_q[i] & (~v_q[i+1] | move[i+1]);
  end

  // in_ready depends only on valid bits and out_ready, never on in_valid.
  assign in_ready_run = ~v_q[0] | move[0];
  assign load[0]      = in_valid & in_ready_run;
  for (genvar i = 1; i < STAGES; i++) begin : g_load
    assign load[i] = move[i-1];
  end

  assign in_ready  = ~clear_mode & in_ready_run;
  assign out_valid = ~clear_mode & v_q[L];
  assign ce        = clear_mode ? '0 : load;
  assign clr       = {STAGES{clear_mode}};
  assign occupancy = occ_q;
  assign busy      = (occ_q != '0);

  // Next valid bits and item count; both collapse to empty while clearing.
  always_comb begin
    v_d   = load | (v_q & ~move);
    occ_d = occ_q + DSP_OCC_W'(load[0]) - DSP_OCC_W'(move[L]);
    if (clear_mode) begin
      v_d   = '0;
      occ_d = '0;
    end
  end

  // Control state machine: one INIT cycle after reset, then RUN/FLUSH on the flush level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DSP_CTRL_INIT;
    end else begin
      case (state_q)
        DSP_CTRL_INIT:  state_q <= DSP_CTRL_RUN;
        DSP_CTRL_RUN:   if (flush)  state_q <= DSP_CTRL_FLUSH;
        DSP_CTRL_FLUSH: if (!flush) state_q <= DSP_CTRL_RUN;
        default:        state_q <= DSP_CTRL_INIT;
      endcase
    end
  end

  // Per-stage valid bits and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// Randomized and directed bench for dsp_pipe_ctrl at STAGES=4 and STAGES=1,
// checked against an item-position queue model plus a ce/clr-driven shadow
// datapath that carries item tags to confirm ordering.
module tb_dsp_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;

  always #5 clk = ~clk;

  logic       ir4, ov4, busy4;
  logic [3:0] ce4, clr4;
  logic [2:0] occ4;
  logic       ir1, ov1, busy1;
  logic [0:0] ce1, clr1;
  logic [2:0] occ1;

  dsp_pipe_ctrl #(.STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
    .out_valid(ov4), .out_ready(out_ready), .flush(flush),
    .ce(ce4), .clr(clr4), .occupancy(occ4), .busy(busy4)
  );

  dsp_pipe_ctrl #(.STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .out_valid(ov1), .out_ready(out_ready), .flush(flush),
    .ce(ce1), .clr(clr1), .occupancy(occ1), .busy(busy1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit         sel1 = 1'b0;
  int         L = 3;
  logic       o_ir, o_ov, o_busy;
  logic [3:0] o_ce, o_clr;
  logic [2:0] o_occ;

  always_comb begin
    if (sel1) begin
      o_ir = ir1; o_ov = ov1; o_busy = busy1;
      o_ce = {3'b000, ce1}; o_clr = {3'b000, clr1}; o_occ = occ1;
    end else begin
      o_ir = ir4; o_ov = ov4; o_busy = busy4;
      o_ce = ce4; o_clr = clr4; o_occ = occ4;
    end
  end

  // Reference model: queue of in-flight items (oldest first) with stage positions.
  int pos[$];
  int ids[$];
  bit m_init = 1'b1;
  int next_id = 1;
  int peak = 0;
  int sh[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, advance model at posedge.
  task automatic cyc(input bit iv, input bit ordy, input bit fl);
    bit clear, exp_ov, popped, exp_ir, load0;
    int np[$];
    int prevnew, p, off, nsh[4];
    logic [3:0] exp_ce, exp_clr;
    in_valid = iv; out_ready = ordy; flush = fl;
    @(negedge clk);
    clear   = m_init || fl || !rst_n;
    exp_ov  = !clear && pos.size() > 0 && pos[0] == L;
    popped  = exp_ov && ordy;
    off     = popped ? 1 : 0;
    prevnew = L + 1;
    np = {};
    for (int k = off; k < pos.size(); k++) begin
      p = pos[k] + 1;
      if (p > prevnew - 1) p = prevnew - 1;
      np.push_back(p);
      prevnew = p;
    end
    exp_ir = !clear && prevnew >= 1;
    load0  = iv && exp_ir;
    exp_ce = 4'h0;
    if (!clear) begin
      exp_ce[0] = load0;
      for (int k = 0; k < np.size(); k++)
        if (np[k] != pos[k+off]) exp_ce[np[k]] = 1'b1;
    end
    exp_clr = clear ? 4'((1 << (L + 1)) - 1) : 4'h0;
    check("in_ready", o_ir, exp_ir);
    check("out_valid", o_ov, exp_ov);
    check("ce", o_ce, exp_ce);
    check("clr", o_clr, exp_clr);
    check("occupancy", o_occ, pos.size());
    check("busy", o_busy, pos.size() != 0);
    if (popped) check("out_item", sh[L], ids[0]);
    for (int i = 0; i < 4; i++) begin
      if (o_ce[i]) nsh[i] = (i == 0) ? next_id : sh[(i == 0) ? 0 : i-1];
      else if (o_clr[i]) nsh[i] = 0;
      else nsh[i] = sh[i];
    end
    @(posedge clk);
    sh = nsh;
    if (clear) begin
      pos.delete(); ids.delete();
      if (rst_n) m_init = 1'b0;
    end else begin
      if (popped) void'(ids.pop_front());
      pos = np;
      if (load0) begin
        pos.push_back(0); ids.push_back(next_id); next_id++;
      end
    end
    if (pos.size() > peak) peak = pos.size();
    #1;
  endtask

  // Full reset of both instances; selects which one is checked afterwards.
  task automatic do_reset(input bit which);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    sel1 = which; L = which ? 0 : 3;
    m_init = 1'b1; pos.delete(); ids.delete();
    for (int i = 0; i < 4; i++) sh[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", o_ir, 0);
    check("rst_out_valid", o_ov, 0);
    check("rst_occupancy", o_occ, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ce", o_ce, 0);
    check("rst_clr", o_clr, which ? 4'h1 : 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // STAGES=4
    do_reset(1'b0);
    peak = 0;
    repeat (8) cyc(1, 1, 0);
    repeat (6) cyc(0, 1, 0);
    check("stream_peak", peak, 4);

    repeat (2) cyc(1, 1, 0);
    repeat (5) cyc(1, 0, 0);
    check("bp_occupancy", o_occ, 4);
    check("bp_in_ready", o_ir, 0);
    check("bp_ce", o_ce, 0);
    repeat (4) cyc(1, 1, 0);
    repeat (6) cyc(0, 1, 0);

    cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    check("bubble_ce32", o_ce[3:2], 0);
    check("bubble_occ", o_occ, 2);
    repeat (4) cyc(0, 1, 0);

    repeat (3) cyc(1, 0, 0);
    check("pre_flush_occ", o_occ, 3);
    cyc(1, 1, 1); cyc(1, 1, 1);
    cyc(0, 0, 0);
    check("post_flush_occ", o_occ, 0);

    repeat (300) cyc($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    repeat (6) cyc(0, 1, 0);

    // STAGES=1
    do_reset(1'b1);
    repeat (6) cyc(1, 1, 0);
    check("s1_occ_steady", o_occ, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", ov1, 0);
    check("async_occ", occ1, 0);
    check("async_clr", clr1, 1);
    m_init = 1'b1; pos.delete(); ids.delete();
    for (int i = 0; i < 4; i++) sh[i] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) cyc(1, 1, 0);
    repeat (200) cyc($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
